// File: rtl/mru_mesi_snoop_resp_pkg.sv
// Shared MRU coherence types: MESI states/actions, the latched request, the
// responder FSM encoding and the address split helper.
package mru_mesi_snoop_resp_pkg;

  localparam int MRU_AW             = 32;
  localparam int MRU_DW             = 32;
  localparam int MRU_CACHE_WAY      = 2;
  localparam int MRU_CACHE_SET      = 64;
  localparam int MRU_CACHE_LINE_LEN = 8;
  localparam int MRU_WAY_W          = $clog2(MRU_CACHE_WAY);
  localparam int MRU_SET_W          = $clog2(MRU_CACHE_SET);
  localparam int MRU_LINE_W         = $clog2(MRU_CACHE_LINE_LEN);
  localparam int MRU_OFF_W          = $clog2(MRU_DW / 8) + MRU_LINE_W;
  localparam int MRU_TAG_W          = MRU_AW - MRU_SET_W - MRU_OFF_W;

  typedef enum logic [1:0] {
    MESI_INVALID   = 2'd0,
    MESI_SHARED    = 2'd1,
    MESI_EXCLUSIVE = 2'd2,
    MESI_MODIFIED  = 2'd3
  } mesi_state_t;

  typedef enum logic [1:0] {
    MESI_ACT_NULL    = 2'd0,
    MESI_ACT_REFILL  = 2'd1,
    MESI_ACT_FORWARD = 2'd2,
    MESI_ACT_REVOKE  = 2'd3
  } mesi_action_t;

  // Only the tag/set of the address are kept; offset bits are never needed.
  typedef struct packed {
    mesi_action_t           act;
    logic [MRU_TAG_W-1:0]   tag;
    logic [MRU_SET_W-1:0]   set;
    logic [MRU_WAY_W-1:0]   way;
    mesi_state_t            state;
  } mesi_req_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, DECIDE, SEND, FILL, UPDATE, ACK
  } snp_fsm_t;

  typedef struct packed {
    logic [MRU_TAG_W-1:0] tag;
    logic [MRU_SET_W-1:0] set;
  } mru_tag_set_t;

  function automatic mru_tag_set_t mru_addr_split(input logic [MRU_AW-1:0] addr);
    mru_tag_set_t r;
    r.set = addr[MRU_OFF_W +: MRU_SET_W];
    r.tag = addr[MRU_AW-1 -: MRU_TAG_W];
    return r;
  endfunction

endpackage

// File: rtl/mru_mesi_snoop_resp_line_reader.sv
// Streams one cache line out of the data RAM: read strobe, one-cycle capture
// into the response register, word counter advancing on each accepted beat.
module mru_snoop_line_reader #(
  parameter int DW       = 32,
  parameter int LINE_LEN = 8,
  parameter int BASE_W   = 7,
  localparam int LINE_W  = $clog2(LINE_LEN)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic [BASE_W-1:0]        base,
  output logic                     dat_rd_en,
  output logic [BASE_W+LINE_W-1:0] dat_rd_adr,
  input  logic [DW-1:0]            dat_rd_data,
  input  logic                     rsp_ready,
  output logic                     rsp_valid,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_last,
  output logic                     done
);

  logic [LINE_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              vld_q, vld_d;
  logic [DW-1:0]     data_q;
  logic              xfer, last_word, issue;

  // The next read may be issued in the same cycle the current word is taken,
  // so the read address uses the post-increment counter.
  always_comb begin
    last_word = (cnt_q == LINE_W'(LINE_LEN - 1));
    xfer      = vld_q && rsp_ready;
    issue     = en && !pend_q && (!vld_q || (xfer && !last_word));
    cnt_d     = xfer ? cnt_q + 1'b1 : cnt_q;
    pend_d    = issue;
    vld_d     = pend_q || (vld_q && !rsp_ready);
    done      = xfer && last_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_q) data_q <= dat_rd_data;
  end

  always_comb begin
    dat_rd_en  = issue;
    dat_rd_adr = issue ? {base, cnt_d} : '0;
    rsp_valid  = vld_q;
    rsp_data   = vld_q ? data_q : '0;
    rsp_last   = vld_q && last_word;
  end

endmodule

// File: rtl/mru_mesi_snoop_resp.sv
// Per-core MESI responder: services REFILL/FORWARD/REVOKE/NULL actions against
// the local tag and data RAMs and returns an ack or a line of data.
module mru_mesi_snoop_resp
  import mru_mesi_snoop_resp_pkg::*;
#(
  parameter int AW             = MRU_AW,
  parameter int DW             = MRU_DW,
  parameter int CACHE_WAY      = MRU_CACHE_WAY,
  parameter int CACHE_SET      = MRU_CACHE_SET,
  parameter int CACHE_LINE_LEN = MRU_CACHE_LINE_LEN,
  parameter int TAG_W          = AW - $clog2(CACHE_SET) - $clog2(CACHE_LINE_LEN) - $clog2(DW/8),
  localparam int WAY_W         = $clog2(CACHE_WAY),
  localparam int SET_W         = $clog2(CACHE_SET),
  localparam int LINE_W        = $clog2(CACHE_LINE_LEN),
  localparam int DADR_W        = WAY_W + SET_W + LINE_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [1:0]                 act_type,
  input  logic [AW-1:0]              act_addr,
  input  logic [WAY_W-1:0]           act_way,
  input  logic [1:0]                 act_state,
  input  logic                       rdat_valid,
  output logic                       rdat_ready,
  input  logic [DW-1:0]              rdat,
  output logic                       tag_rd_en,
  output logic [SET_W-1:0]           tag_rd_set,
  input  logic [CACHE_WAY*TAG_W-1:0] tag_rd_tag,
  input  logic [CACHE_WAY*2-1:0]     tag_rd_state,
  output logic                       tag_wr_en,
  output logic [SET_W-1:0]           tag_wr_set,
  output logic [WAY_W-1:0]           tag_wr_way,
  output logic [TAG_W-1:0]           tag_wr_tag,
  output logic [1:0]                 tag_wr_state,
  output logic                       dat_rd_en,
  output logic [DADR_W-1:0]          dat_rd_adr,
  input  logic [DW-1:0]              dat_rd_data,
  output logic                       dat_wr_en,
  output logic [DADR_W-1:0]          dat_wr_adr,
  output logic [DW-1:0]              dat_wr_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_hit,
  output logic                       rsp_dirty,
  output logic                       rsp_last,
  output logic [DW-1:0]              rsp_data,
  output logic                       busy
);

  snp_fsm_t          state_q, state_d;
  mesi_req_t         req_q, req_d;
  logic [LINE_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              act_ready_q, act_ready_d;
  logic              hit_q, hit_d;
  logic              dirty_q, dirty_d;
  logic              ack_hit_q, ack_hit_d;
  logic              upd_ack_q, upd_ack_d;
  logic [WAY_W-1:0]  hit_way_q, hit_way_d;
  logic [WAY_W-1:0]  upd_way_q, upd_way_d;
  mesi_state_t       old_st_q, old_st_d;
  mesi_state_t       new_st_q, new_st_d;

  mru_tag_set_t      act_split;
  logic              lk_hit;
  logic [WAY_W-1:0]  lk_way;
  mesi_state_t       lk_st;
  logic              rd_valid, rd_last, rd_done;
  logic [DW-1:0]     rd_data;
  mesi_action_t      act_in;

  assign act_split = mru_addr_split(act_addr);
  assign act_in    = mesi_action_t'(act_type);

  // Descending scan so the lowest matching way wins if the tags are duplicated.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    lk_st  = MESI_INVALID;
    for (int w = CACHE_WAY - 1; w >= 0; w--) begin
      if (tag_rd_tag[w*TAG_W +: TAG_W] == req_q.tag &&
          mesi_state_t'(tag_rd_state[w*2 +: 2]) != MESI_INVALID) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
        lk_st  = mesi_state_t'(tag_rd_state[w*2 +: 2]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      act_ready_q <= 1'b0;
      fill_cnt_q  <= '0;
      hit_q       <= 1'b0;
      dirty_q     <= 1'b0;
      ack_hit_q   <= 1'b0;
      upd_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_ready_q <= act_ready_d;
      fill_cnt_q  <= fill_cnt_d;
      hit_q       <= hit_d;
      dirty_q     <= dirty_d;
      ack_hit_q   <= ack_hit_d;
      upd_ack_q   <= upd_ack_d;
    end
  end

  always_ff @(posedge clk) begin
    req_q     <= req_d;
    hit_way_q <= hit_way_d;
    upd_way_q <= upd_way_d;
    old_st_q  <= old_st_d;
    new_st_q  <= new_st_d;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    fill_cnt_d = fill_cnt_q;
    hit_d      = hit_q;
    dirty_d    = dirty_q;
    ack_hit_d  = ack_hit_q;
    upd_ack_d  = upd_ack_q;
    hit_way_d  = hit_way_q;
    upd_way_d  = upd_way_q;
    old_st_d   = old_st_q;
    new_st_d   = new_st_q;
    unique case (state_q)
      IDLE: begin
        if (act_valid && act_ready_q) begin
          req_d.act   = act_in;
          req_d.tag   = act_split.tag;
          req_d.set   = act_split.set;
          req_d.way   = act_way;
          req_d.state = mesi_state_t'(act_state);
          fill_cnt_d  = '0;
          dirty_d     = 1'b0;
          ack_hit_d   = 1'b0;
          unique case (act_in)
            MESI_ACT_REFILL: state_d = FILL;
            MESI_ACT_NULL:   state_d = ACK;
            default:         state_d = LOOKUP;
          endcase
        end
      end
      LOOKUP: begin
        hit_d     = lk_hit;
        hit_way_d = lk_way;
        old_st_d  = lk_st;
        state_d   = DECIDE;
      end
      DECIDE: begin
        upd_way_d = hit_way_q;
        upd_ack_d = 1'b0;
        if (!hit_q) begin
          ack_hit_d = 1'b0;
          dirty_d   = 1'b0;
          state_d   = ACK;
        end else if (req_q.act == MESI_ACT_FORWARD) begin
          dirty_d  = (old_st_q == MESI_MODIFIED);
          new_st_d = MESI_SHARED;
          state_d  = SEND;
        end else if (old_st_q == MESI_MODIFIED) begin
          dirty_d  = 1'b1;
          new_st_d = MESI_INVALID;
          state_d  = SEND;
        end else begin
          dirty_d   = 1'b0;
          ack_hit_d = 1'b1;
          upd_ack_d = 1'b1;
          new_st_d  = MESI_INVALID;
          state_d   = UPDATE;
        end
      end
      SEND: begin
        if (rd_done) state_d = UPDATE;
      end
      FILL: begin
        if (rdat_valid) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == LINE_W'(CACHE_LINE_LEN - 1)) begin
            upd_way_d = req_q.way;
            new_st_d  = req_q.state;
            upd_ack_d = 1'b1;
            ack_hit_d = 1'b1;
            state_d   = UPDATE;
          end
        end
      end
      UPDATE: state_d = upd_ack_q ? ACK : IDLE;
      ACK: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    act_ready_d = (state_d == IDLE);
  end

  mru_snoop_line_reader #(
    .DW       (DW),
    .LINE_LEN (CACHE_LINE_LEN),
    .BASE_W   (WAY_W + SET_W)
  ) u_line_reader (
    .clk         (clk),
    .rstn        (rstn),
    .en          (state_q == SEND),
    .base        ({hit_way_q, req_q.set}),
    .dat_rd_en   (dat_rd_en),
    .dat_rd_adr  (dat_rd_adr),
    .dat_rd_data (dat_rd_data),
    .rsp_ready   (rsp_ready),
    .rsp_valid   (rd_valid),
    .rsp_data    (rd_data),
    .rsp_last    (rd_last),
    .done        (rd_done)
  );

  // Every address/data field is zeroed while its strobe is low.
  always_comb begin
    act_ready    = act_ready_q;
    busy         = (state_q != IDLE);
    tag_rd_en    = (state_q == IDLE) && act_valid && act_ready_q &&
                   (act_in == MESI_ACT_FORWARD || act_in == MESI_ACT_REVOKE);
    tag_rd_set   = tag_rd_en ? act_split.set : '0;
    rdat_ready   = (state_q == FILL);
    dat_wr_en    = rdat_ready && rdat_valid;
    dat_wr_adr   = dat_wr_en ? {req_q.way, req_q.set, fill_cnt_q} : '0;
    dat_wr_data  = dat_wr_en ? rdat : '0;
    tag_wr_en    = (state_q == UPDATE);
    tag_wr_set   = tag_wr_en ? req_q.set : '0;
    tag_wr_way   = tag_wr_en ? upd_way_q : '0;
    tag_wr_tag   = tag_wr_en ? req_q.tag : '0;
    tag_wr_state = tag_wr_en ? new_st_q : 2'b00;
    rsp_valid    = 1'b0;
    rsp_hit      = 1'b0;
    rsp_dirty    = 1'b0;
    rsp_last     = 1'b0;
    rsp_data     = '0;
    if (state_q == SEND) begin
      rsp_valid = rd_valid;
      rsp_hit   = rd_valid;
      rsp_dirty = rd_valid && dirty_q;
      rsp_last  = rd_last;
      rsp_data  = rd_data;
    end else if (state_q == ACK) begin
      rsp_valid = 1'b1;
      rsp_hit   = ack_hit_q;
      rsp_last  = 1'b1;
    end
  end

endmodule

// File: tb/tb_mru_mesi_snoop_resp.sv
// Directed and randomized bench for mru_mesi_snoop_resp with bench-side tag/data
// RAMs and a line-level MESI reference model.
module tb_mru_mesi_snoop_resp;
  import mru_mesi_snoop_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        act_valid, act_ready;
  logic [1:0]  act_type;
  logic [31:0] act_addr;
  logic        act_way;
  logic [1:0]  act_state;
  logic        rdat_valid, rdat_ready;
  logic [31:0] rdat;
  logic        tag_rd_en;
  logic [5:0]  tag_rd_set;
  logic [41:0] tag_rd_tag;
  logic [3:0]  tag_rd_state;
  logic        tag_wr_en;
  logic [5:0]  tag_wr_set;
  logic        tag_wr_way;
  logic [20:0] tag_wr_tag;
  logic [1:0]  tag_wr_state;
  logic        dat_rd_en;
  logic [9:0]  dat_rd_adr;
  logic [31:0] dat_rd_data;
  logic        dat_wr_en;
  logic [9:0]  dat_wr_adr;
  logic [31:0] dat_wr_data;
  logic        rsp_valid, rsp_ready, rsp_hit, rsp_dirty, rsp_last;
  logic [31:0] rsp_data;
  logic        busy;

  always #5 clk = ~clk;

  mru_mesi_snoop_resp dut (
    .clk(clk), .rstn(rstn),
    .act_valid(act_valid), .act_ready(act_ready), .act_type(act_type),
    .act_addr(act_addr), .act_way(act_way), .act_state(act_state),
    .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat(rdat),
    .tag_rd_en(tag_rd_en), .tag_rd_set(tag_rd_set), .tag_rd_tag(tag_rd_tag),
    .tag_rd_state(tag_rd_state),
    .tag_wr_en(tag_wr_en), .tag_wr_set(tag_wr_set), .tag_wr_way(tag_wr_way),
    .tag_wr_tag(tag_wr_tag), .tag_wr_state(tag_wr_state),
    .dat_rd_en(dat_rd_en), .dat_rd_adr(dat_rd_adr), .dat_rd_data(dat_rd_data),
    .dat_wr_en(dat_wr_en), .dat_wr_adr(dat_wr_adr), .dat_wr_data(dat_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_dirty(rsp_dirty), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .busy(busy)
  );

  wire outs_any = |{act_ready, rdat_ready, tag_rd_en, tag_rd_set, tag_wr_en,
                    tag_wr_set, tag_wr_way, tag_wr_tag, tag_wr_state, dat_rd_en,
                    dat_rd_adr, dat_wr_en, dat_wr_adr, dat_wr_data, rsp_valid,
                    rsp_hit, rsp_dirty, rsp_last, rsp_data, busy};

  // Bench-side RAMs; the backdoor port lets a test change a line's state.
  logic [20:0] r_tag [2][64];
  logic [1:0]  r_st  [2][64];
  logic [31:0] r_dat [1024];
  logic        mem_clr, bd_en, bd_way;
  logic [5:0]  bd_set;
  logic [1:0]  bd_st;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 64; s++) begin
          r_tag[w][s] <= '0;
          r_st[w][s]  <= 2'd0;
        end
    end else begin
      if (tag_wr_en) begin
        r_tag[tag_wr_way][tag_wr_set] <= tag_wr_tag;
        r_st[tag_wr_way][tag_wr_set]  <= tag_wr_state;
      end
      if (bd_en) r_st[bd_way][bd_set] <= bd_st;
      if (dat_wr_en) r_dat[dat_wr_adr] <= dat_wr_data;
    end
    if (tag_rd_en) begin
      tag_rd_tag   <= {r_tag[1][tag_rd_set], r_tag[0][tag_rd_set]};
      tag_rd_state <= {r_st[1][tag_rd_set], r_st[0][tag_rd_set]};
    end
    if (dat_rd_en) dat_rd_data <= r_dat[dat_rd_adr];
  end

  typedef struct packed {logic [31:0] data; logic hit; logic dirty; logic last;} beat_t;
  typedef struct packed {logic [9:0] adr; logic [31:0] data;} dw_t;
  typedef struct packed {logic way; logic [5:0] set; logic [20:0] tag; logic [1:0] st;} tw_t;

  // Reference model: cache contents as the protocol says they should be.
  logic [20:0] m_tag [2][64];
  logic [1:0]  m_st  [2][64];
  logic [31:0] m_dat [2][64][8];
  logic [31:0] fill_words [8];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic backdoor_state(input logic w, input logic [5:0] s, input logic [1:0] st);
    @(negedge clk);
    bd_en = 1'b1; bd_way = w; bd_set = s; bd_st = st;
    @(negedge clk);
    bd_en = 1'b0;
    m_st[w][s] = st;
  endtask

  task automatic run_action(input string name, input logic [1:0] act, input logic [31:0] addr,
                            input logic w, input logic [1:0] st, input int gap, input int rmode);
    beat_t exp_b[$], obs_b[$];
    dw_t   exp_dw[$], obs_dw[$];
    tw_t   exp_tw[$], obs_tw[$];
    int    exp_rd, rd_cnt, wi, hw;
    logic  accepted, got_last, done, prev_hold, dirty;
    logic [35:0] prev_rsp;
    logic [5:0]  set;
    logic [20:0] tag;

    set = addr[10:5];
    tag = addr[31:11];
    exp_rd = 0;
    if (act == MESI_ACT_NULL) begin
      exp_b.push_back('{32'd0, 1'b0, 1'b0, 1'b1});
    end else if (act == MESI_ACT_REFILL) begin
      for (int i = 0; i < 8; i++) begin
        exp_dw.push_back('{10'(int'(w) * 512 + int'(set) * 8 + i), fill_words[i]});
        m_dat[w][set][i] = fill_words[i];
      end
      exp_tw.push_back('{w, set, tag, st});
      m_tag[w][set] = tag;
      m_st[w][set]  = st;
      exp_b.push_back('{32'd0, 1'b1, 1'b0, 1'b1});
    end else begin
      hw = -1;
      for (int k = 0; k < 2; k++)
        if (hw < 0 && m_st[k][set] != MESI_INVALID && m_tag[k][set] == tag) hw = k;
      if (hw < 0) begin
        exp_b.push_back('{32'd0, 1'b0, 1'b0, 1'b1});
      end else begin
        dirty = (m_st[hw][set] == MESI_MODIFIED);
        if (act == MESI_ACT_FORWARD || dirty) begin
          for (int i = 0; i < 8; i++) exp_b.push_back('{m_dat[hw][set][i], 1'b1, dirty, i == 7});
          exp_rd = 8;
          m_st[hw][set] = (act == MESI_ACT_FORWARD) ? MESI_SHARED : MESI_INVALID;
          exp_tw.push_back('{hw[0], set, tag, m_st[hw][set]});
        end else begin
          m_st[hw][set] = MESI_INVALID;
          exp_tw.push_back('{hw[0], set, tag, 2'd0});
          exp_b.push_back('{32'd0, 1'b1, 1'b0, 1'b1});
        end
      end
    end

    accepted = 0; got_last = 0; done = 0; prev_hold = 0; prev_rsp = '0;
    wi = 0; rd_cnt = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      act_valid  = !accepted;
      act_type   = act; act_addr = addr; act_way = w; act_state = st;
      rdat_valid = (act == MESI_ACT_REFILL) && accepted && wi < 8 && (gap == 0 || cyc % 2 == 1);
      rdat       = (wi < 8) ? fill_words[wi] : 32'd0;
      rsp_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (prev_hold) check({name, "_rsp_stable"}, {rsp_valid, rsp_data, rsp_hit, rsp_dirty, rsp_last}, prev_rsp);
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = {rsp_valid, rsp_data, rsp_hit, rsp_dirty, rsp_last};
      if (act_valid && act_ready) accepted = 1;
      if (rdat_valid && rdat_ready) wi++;
      if (dat_wr_en) obs_dw.push_back('{dat_wr_adr, dat_wr_data});
      if (tag_wr_en) obs_tw.push_back('{tag_wr_way, tag_wr_set, tag_wr_tag, tag_wr_state});
      if (dat_rd_en) rd_cnt++;
      if (rsp_valid && rsp_ready) begin
        obs_b.push_back('{rsp_data, rsp_hit, rsp_dirty, rsp_last});
        if (rsp_last) got_last = 1;
      end
      if (accepted && got_last && !busy) done = 1;
    end
    act_valid = 0; rdat_valid = 0;
    check({name, "_done"}, done, 1'b1);
    check({name, "_beats_n"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) check({name, "_beat"}, obs_b[i], exp_b[i]);
    check({name, "_dw_n"}, obs_dw.size(), exp_dw.size());
    for (int i = 0; i < exp_dw.size() && i < obs_dw.size(); i++) check({name, "_dw"}, obs_dw[i], exp_dw[i]);
    check({name, "_tw_n"}, obs_tw.size(), exp_tw.size());
    for (int i = 0; i < exp_tw.size() && i < obs_tw.size(); i++) check({name, "_tw"}, obs_tw[i], exp_tw[i]);
    check({name, "_rd_n"}, rd_cnt, exp_rd);
  endtask

  initial begin
    logic [31:0] pool [4];
    int wi, n_dw, n_tw, r;
    logic acc;

    rstn = 0; mem_clr = 1; bd_en = 0; bd_way = 0; bd_set = '0; bd_st = '0;
    act_valid = 0; act_type = '0; act_addr = '0; act_way = 0; act_state = '0;
    rdat_valid = 0; rdat = '0; rsp_ready = 0;
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 64; s++) begin
        m_tag[w][s] = '0; m_st[w][s] = 2'd0;
      end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_outs", outs_any, 1'b0);
    rstn = 1; mem_clr = 0;
    @(negedge clk); #1;
    check("reset_act_ready", act_ready, 1'b1);
    check("reset_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) fill_words[i] = 32'hA0 + 32'(i);
    run_action("refill1", MESI_ACT_REFILL, 32'h1040, 1'b1, MESI_EXCLUSIVE, 0, 0);
    backdoor_state(1'b1, 6'd2, MESI_MODIFIED);
    run_action("fwd_mod", MESI_ACT_FORWARD, 32'h1040, 1'b0, 2'd0, 0, 1);
    run_action("revoke_sh", MESI_ACT_REVOKE, 32'h1040, 1'b0, 2'd0, 0, 0);
    run_action("fwd_gone", MESI_ACT_FORWARD, 32'h1040, 1'b0, 2'd0, 0, 0);
    run_action("fwd_absent", MESI_ACT_FORWARD, 32'h7000_0040, 1'b0, 2'd0, 0, 2);
    for (int i = 0; i < 8; i++) fill_words[i] = $urandom;
    run_action("refill_gap", MESI_ACT_REFILL, 32'h2460, 1'b0, MESI_MODIFIED, 1, 0);
    run_action("revoke_mod", MESI_ACT_REVOKE, 32'h2460, 1'b0, 2'd0, 0, 2);
    run_action("null", MESI_ACT_NULL, 32'h0, 1'b0, 2'd0, 0, 1);

    for (int k = 0; k < 4; k++) pool[k] = {21'($urandom), (k % 2 == 0) ? 6'd5 : 6'd9, 5'd0};
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 8; i++) fill_words[i] = $urandom;
      r = $urandom_range(0, 9);
      run_action("rand", (r < 4) ? MESI_ACT_REFILL : (r < 6) ? MESI_ACT_FORWARD :
                         (r < 9) ? MESI_ACT_REVOKE : MESI_ACT_NULL,
                 pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                 2'($urandom_range(1, 3)), $urandom_range(0, 1), $urandom_range(0, 2));
    end

    // Reset in the middle of a refill, after three words have been written.
    acc = 0; wi = 0; n_dw = 0; n_tw = 0;
    for (int cyc = 0; cyc < 50 && wi < 3; cyc++) begin
      @(negedge clk);
      act_valid = !acc; act_type = MESI_ACT_REFILL; act_addr = 32'h3080;
      act_way = 0; act_state = MESI_EXCLUSIVE;
      rdat_valid = acc; rdat = 32'hC0 + 32'(wi); rsp_ready = 1;
      #1;
      if (act_valid && act_ready) acc = 1;
      if (dat_wr_en) n_dw++;
      if (tag_wr_en) n_tw++;
      if (rdat_valid && rdat_ready) wi++;
    end
    check("rst_mid_words", wi, 3);
    @(negedge clk);
    rstn = 0; act_valid = 0; rdat_valid = 1; rdat = 32'hC3;
    #1;
    check("rst_mid_outs", outs_any, 1'b0);
    check("rst_mid_dw_n", n_dw, 3);
    @(negedge clk);
    rstn = 1; rdat_valid = 0;
    #1;
    if (tag_wr_en) n_tw++;
    @(negedge clk); #1;
    if (tag_wr_en) n_tw++;
    check("rst_mid_act_ready", act_ready, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_tw_n", n_tw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
